// File: rtl/warp_scoreboard.sv
// Per-warp register scoreboard: shadows buffered packet registers, tracks pending dest writes, drives hazards.
// Optional SB_INORDER_EN: entry 1 of a warp is held while entry 0 of that warp is valid.
module warp_scoreboard #(
  parameter int NUM_WARP     = 4,
  parameter int NUM_WARP_LOG = 2,
  parameter int RW           = 5,
  parameter int SB_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_WARP_LOG-1:0] decodedWarp_i,
  input  logic                    decodedPacket0Valid_i,
  input  logic                    decodedPacket1Valid_i,
  input  logic [4*(RW+1)-1:0]     decodedRegs0_i,
  input  logic [4*(RW+1)-1:0]     decodedRegs1_i,
  input  logic                    flush_i,
  input  logic [NUM_WARP_LOG-1:0] flushWarp_i,
  input  logic                    stall_i,
  input  logic                    issueValid_i,
  input  logic [NUM_WARP_LOG-1:0] issueWarp_i,
  input  logic                    issueEntry_i,
  input  logic                    issueDstValid_i,
  input  logic [RW-1:0]           issueDst_i,
  input  logic                    wbValid_i,
  input  logic [NUM_WARP_LOG-1:0] wbWarp_i,
  input  logic [RW-1:0]           wbReg_i,
  output logic [NUM_WARP-1:0]     hazardVector0_o,
  output logic [NUM_WARP-1:0]     hazardVector1_o,
  output logic [NUM_WARP-1:0]     sbEmptyVector_o,
  output logic                    overflow_o
);
  localparam int FW  = RW + 1;
  localparam int PW  = 4 * FW;
  localparam int SLW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

  logic [NUM_WARP-1:0]    s0_valid, s1_valid, s0_valid_n, s1_valid_n;
  logic [PW-1:0]          s0_regs [NUM_WARP];
  logic [PW-1:0]          s1_regs [NUM_WARP];
  logic [SB_DEPTH-1:0]    slot_valid   [NUM_WARP];
  logic [SB_DEPTH-1:0]    slot_valid_n [NUM_WARP];
  logic [SB_DEPTH*RW-1:0] slot_addr    [NUM_WARP];
  logic [SB_DEPTH*RW-1:0] slot_addr_n  [NUM_WARP];
  logic                   overflow_q, overflow_n;
  logic                   cap0, cap1, issue_q, free_found;
  logic [SLW-1:0]         free_idx;

  // Same qualification as the buffer's RAM write enable and selection.
  assign cap0    = decodedPacket0Valid_i && !stall_i && !(flush_i && flushWarp_i == decodedWarp_i);
  assign cap1    = decodedPacket1Valid_i && !stall_i && !(flush_i && flushWarp_i == decodedWarp_i);
  assign issue_q = issueValid_i && !stall_i && !(flush_i && flushWarp_i == issueWarp_i);

  always_comb begin
    s0_valid_n = s0_valid;
    s1_valid_n = s1_valid;
    if (flush_i) begin
      s0_valid_n[flushWarp_i] = 1'b0;
      s1_valid_n[flushWarp_i] = 1'b0;
    end
    if (issue_q) begin
      if (issueEntry_i) s1_valid_n[issueWarp_i] = 1'b0;
      else              s0_valid_n[issueWarp_i] = 1'b0;
    end
    // Capture is applied last so it wins over an issue-clear of the same entry.
    if (cap0) s0_valid_n[decodedWarp_i] = 1'b1;
    if (cap1) s1_valid_n[decodedWarp_i] = 1'b1;

    for (int w = 0; w < NUM_WARP; w++) begin
      slot_valid_n[w] = slot_valid[w];
      slot_addr_n[w]  = slot_addr[w];
      if (wbValid_i && wbWarp_i == NUM_WARP_LOG'(w)) begin
        for (int s = 0; s < SB_DEPTH; s++) begin
          if (slot_valid[w][s] && slot_addr[w][s*RW +: RW] == wbReg_i) slot_valid_n[w][s] = 1'b0;
        end
      end
    end

    // Free slot is chosen from pre-cycle state; a slot released this cycle is not reused.
    free_found = 1'b0;
    free_idx   = '0;
    for (int s = 0; s < SB_DEPTH; s++) begin
      if (!slot_valid[issueWarp_i][s] && !free_found) begin
        free_found = 1'b1;
        free_idx   = SLW'(s);
      end
    end

    overflow_n = overflow_q;
    if (issue_q && issueDstValid_i) begin
      if (free_found) begin
        slot_valid_n[issueWarp_i][free_idx]         = 1'b1;
        slot_addr_n[issueWarp_i][free_idx*RW +: RW] = issueDst_i;
      end else begin
        overflow_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid   <= '0;
      s1_valid   <= '0;
      overflow_q <= 1'b0;
      for (int w = 0; w < NUM_WARP; w++) begin
        s0_regs[w]    <= '0;
        s1_regs[w]    <= '0;
        slot_valid[w] <= '0;
        slot_addr[w]  <= '0;
      end
    end else begin
      s0_valid   <= s0_valid_n;
      s1_valid   <= s1_valid_n;
      overflow_q <= overflow_n;
      for (int w = 0; w < NUM_WARP; w++) begin
        slot_valid[w] <= slot_valid_n[w];
        slot_addr[w]  <= slot_addr_n[w];
      end
      if (cap0) s0_regs[decodedWarp_i] <= decodedRegs0_i;
      if (cap1) s1_regs[decodedWarp_i] <= decodedRegs1_i;
    end
  end

  function automatic logic entry_hazard(input logic [PW-1:0] regs,
                                        input logic [SB_DEPTH-1:0] sv,
                                        input logic [SB_DEPTH*RW-1:0] sa);
    logic h;
    h = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (regs[k*FW+RW]) begin
        for (int s = 0; s < SB_DEPTH; s++) begin
          if (sv[s] && regs[k*FW +: RW] == sa[s*RW +: RW]) h = 1'b1;
        end
      end
    end
    // A dest with nowhere to be reserved must wait for a free slot.
    if (regs[3*FW+RW] && (&sv)) h = 1'b1;
    return h;
  endfunction

  always_comb begin
    hazardVector0_o = '0;
    hazardVector1_o = '0;
    sbEmptyVector_o = '0;
    for (int w = 0; w < NUM_WARP; w++) begin
      hazardVector0_o[w] = s0_valid[w] && entry_hazard(s0_regs[w], slot_valid[w], slot_addr[w]);
`ifdef SB_INORDER_EN
      hazardVector1_o[w] = s1_valid[w] &&
                           (entry_hazard(s1_regs[w], slot_valid[w], slot_addr[w]) || s0_valid[w]);
`else
      hazardVector1_o[w] = s1_valid[w] && entry_hazard(s1_regs[w], slot_valid[w], slot_addr[w]);
`endif
      sbEmptyVector_o[w] = ~(|slot_valid[w]);
    end
  end

  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_warp_scoreboard.sv
// Directed bench for warp_scoreboard: stimulus pushes expected output snapshots, a negedge monitor compares.
module tb_warp_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  decodedWarp_i;
  logic        decodedPacket0Valid_i, decodedPacket1Valid_i;
  logic [23:0] decodedRegs0_i, decodedRegs1_i;
  logic        flush_i;
  logic [1:0]  flushWarp_i;
  logic        stall_i;
  logic        issueValid_i;
  logic [1:0]  issueWarp_i;
  logic        issueEntry_i;
  logic        issueDstValid_i;
  logic [4:0]  issueDst_i;
  logic        wbValid_i;
  logic [1:0]  wbWarp_i;
  logic [4:0]  wbReg_i;
  logic [3:0]  hazardVector0_o, hazardVector1_o, sbEmptyVector_o;
  logic        overflow_o;

`ifdef SB_INORDER_EN
  localparam logic INORDER = 1'b1;
`else
  localparam logic INORDER = 1'b0;
`endif

  warp_scoreboard dut (
    .clk(clk), .reset(reset),
    .decodedWarp_i(decodedWarp_i),
    .decodedPacket0Valid_i(decodedPacket0Valid_i), .decodedPacket1Valid_i(decodedPacket1Valid_i),
    .decodedRegs0_i(decodedRegs0_i), .decodedRegs1_i(decodedRegs1_i),
    .flush_i(flush_i), .flushWarp_i(flushWarp_i), .stall_i(stall_i),
    .issueValid_i(issueValid_i), .issueWarp_i(issueWarp_i), .issueEntry_i(issueEntry_i),
    .issueDstValid_i(issueDstValid_i), .issueDst_i(issueDst_i),
    .wbValid_i(wbValid_i), .wbWarp_i(wbWarp_i), .wbReg_i(wbReg_i),
    .hazardVector0_o(hazardVector0_o), .hazardVector1_o(hazardVector1_o),
    .sbEmptyVector_o(sbEmptyVector_o), .overflow_o(overflow_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard: expected {hv0, hv1, empty, overflow}
  logic [12:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    logic [12:0] exp_v, act_v;
    string nm;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {hazardVector0_o, hazardVector1_o, sbEmptyVector_o, overflow_o};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s actual hv0=%b hv1=%b empty=%b ovf=%b required hv0=%b hv1=%b empty=%b ovf=%b",
                 nm, act_v[12:9], act_v[8:5], act_v[4:1], act_v[0],
                 exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] hv0, input logic [3:0] hv1,
                     input logic [3:0] emp, input logic ov);
    exp_q.push_back({hv0, hv1, emp, ov});
    name_q.push_back(nm);
  endtask

  // Driver tasks
  function automatic logic [23:0] rg(input logic sv, input logic [4:0] sa,
                                     input logic dv, input logic [4:0] da);
    return {dv, da, 6'b0, 6'b0, sv, sa};
  endfunction

  task automatic idle();
    decodedWarp_i = 0; decodedPacket0Valid_i = 0; decodedPacket1Valid_i = 0;
    decodedRegs0_i = 0; decodedRegs1_i = 0;
    flush_i = 0; flushWarp_i = 0; stall_i = 0;
    issueValid_i = 0; issueWarp_i = 0; issueEntry_i = 0; issueDstValid_i = 0; issueDst_i = 0;
    wbValid_i = 0; wbWarp_i = 0; wbReg_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_dec0(input logic [1:0] w, input logic [23:0] r);
    decodedWarp_i = w; decodedPacket0Valid_i = 1'b1; decodedRegs0_i = r;
  endtask

  task automatic set_dec1(input logic [1:0] w, input logic [23:0] r);
    decodedWarp_i = w; decodedPacket1Valid_i = 1'b1; decodedRegs1_i = r;
  endtask

  task automatic set_issue(input logic [1:0] w, input logic e, input logic dv, input logic [4:0] d);
    issueValid_i = 1'b1; issueWarp_i = w; issueEntry_i = e; issueDstValid_i = dv; issueDst_i = d;
  endtask

  task automatic set_wb(input logic [1:0] w, input logic [4:0] r);
    wbValid_i = 1'b1; wbWarp_i = w; wbReg_i = r;
  endtask

  initial begin
    do_reset();
    chk("reset", 4'b0000, 4'b0000, 4'b1111, 1'b0);

    // RAW across entries of warp 2, released by writeback
    set_dec0(2, rg(1, 3, 1, 7)); step(); idle();
    chk("a_capture", 4'b0000, 4'b0000, 4'b1111, 1'b0);
    set_issue(2, 0, 1, 7); step(); idle();
    chk("a_reserve", 4'b0000, 4'b0000, 4'b1011, 1'b0);
    set_dec1(2, rg(1, 7, 0, 0)); step(); idle();
    chk("a_raw", 4'b0000, 4'b0100, 4'b1011, 1'b0);
    set_wb(2, 7); step(); idle();
    chk("a_release", 4'b0000, 4'b0000, 4'b1111, 1'b0);

    // Fill warp 0, full-dest hazard, overflow
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_issue(0, 0, 1, 5'(i)); step(); idle();
      chk("b_fill", 4'b0000, 4'b0000, 4'b1110, 1'b0);
    end
    set_dec0(0, rg(0, 0, 1, 9)); step(); idle();
    chk("b_full_dest", 4'b0001, 4'b0000, 4'b1110, 1'b0);
    set_issue(0, 1, 1, 10); step(); idle();
    chk("b_overflow", 4'b0001, 4'b0000, 4'b1110, 1'b1);
    repeat (3) step();
    chk("b_sticky", 4'b0001, 4'b0000, 4'b1110, 1'b1);
    set_wb(0, 1); step(); idle();
    chk("b_wb_one", 4'b0000, 4'b0000, 4'b1110, 1'b1);
    for (int r = 2; r <= 4; r++) begin
      set_wb(0, 5'(r)); step(); idle();
    end
    chk("b_drained", 4'b0000, 4'b0000, 4'b1111, 1'b1);
    do_reset();
    chk("b_reset_ovf", 4'b0000, 4'b0000, 4'b1111, 1'b0);

    // Flush on warp 1 blocks issue and capture, keeps pending slots
    set_issue(1, 1, 1, 5); step(); idle();
    chk("c_reserve", 4'b0000, 4'b0000, 4'b1101, 1'b0);
    set_dec0(1, rg(1, 5, 0, 0)); step(); idle();
    chk("c_raw", 4'b0010, 4'b0000, 4'b1101, 1'b0);
    flush_i = 1'b1; flushWarp_i = 2'd1;
    set_issue(1, 0, 1, 6); set_dec1(1, rg(1, 5, 0, 0)); step(); idle();
    chk("c_flush", 4'b0000, 4'b0000, 4'b1101, 1'b0);
    set_wb(1, 5); step(); idle();
    chk("c_no_reserve", 4'b0000, 4'b0000, 4'b1111, 1'b0);

    // Stall freezes issue for 3 cycles; writeback still releases
    do_reset();
    set_issue(3, 0, 1, 2); step(); idle();
    chk("d_reserve", 4'b0000, 4'b0000, 4'b0111, 1'b0);
    stall_i = 1'b1; set_issue(0, 0, 1, 8); step();
    chk("d_stall1", 4'b0000, 4'b0000, 4'b0111, 1'b0);
    set_wb(3, 2); step(); wbValid_i = 1'b0;
    chk("d_stall_wb", 4'b0000, 4'b0000, 4'b1111, 1'b0);
    step();
    chk("d_stall3", 4'b0000, 4'b0000, 4'b1111, 1'b0);
    stall_i = 1'b0; step(); idle();
    chk("d_release", 4'b0000, 4'b0000, 4'b1110, 1'b0);
    for (int r = 11; r <= 13; r++) begin
      set_issue(0, 0, 1, 5'(r)); step(); idle();
    end
    chk("d_fill_no_ovf", 4'b0000, 4'b0000, 4'b1110, 1'b0);
    set_issue(0, 0, 1, 14); step(); idle();
    chk("d_one_reserve", 4'b0000, 4'b0000, 4'b1110, 1'b1);

    // Same-cycle capture and issue on warp 3 entry 0
    do_reset();
    set_dec0(3, rg(1, 1, 1, 6)); step(); idle();
    chk("e_capture", 4'b0000, 4'b0000, 4'b1111, 1'b0);
    set_dec0(3, rg(1, 6, 1, 15)); set_issue(3, 0, 1, 6); step(); idle();
    chk("e_same_cycle", 4'b1000, 4'b0000, 4'b0111, 1'b0);

    // In-order option on warp 0
    do_reset();
    set_dec0(0, rg(1, 1, 0, 0)); set_dec1(0, rg(1, 2, 0, 0)); step(); idle();
    chk("f_inorder", 4'b0000, INORDER ? 4'b0001 : 4'b0000, 4'b1111, 1'b0);
    set_issue(0, 0, 0, 0); step(); idle();
    chk("f_after_issue", 4'b0000, 4'b0000, 4'b1111, 1'b0);

    // Final report
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_scoreboard.md
# warp_scoreboard

Per-warp register scoreboard feeding the two-entry-per-warp instruction buffer. It shadows the register fields of every buffered packet and tracks outstanding destination-register writes per warp. From these it drives the buffer's `hazardVector0/1` inputs combinationally. Reservations are made from the buffer's selection outputs and released by the writeback stage.

## Interface
- `NUM_WARP`, 4: warps.
- `NUM_WARP_LOG`, 2: warp index width.
- `RW`, 5: register address width (`SIZE_REGFILE`).
- `SB_DEPTH`, 4: pending-write slots per warp.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `decodedWarp_i` in `NUM_WARP_LOG`: warp being written into the buffer.
- `decodedPacket0Valid_i` / `decodedPacket1Valid_i` in 1: entry 0 / entry 1 write.
- `decodedRegs0_i` / `decodedRegs1_i` in `4*(RW+1)`: four fields `{valid, addr}`. Field k occupies `[(k+1)(RW+1)-1 : k(RW+1)]`. k=0..2 are sources; k=3 is the destination.
- `flush_i` in 1: flush request.
- `flushWarp_i` in `NUM_WARP_LOG`: warp to flush.
- `stall_i` in 1: pipeline stall.
- `issueValid_i` in 1: buffer `toSelectPacketValid_o`.
- `issueWarp_i` in `NUM_WARP_LOG`: buffer `toSelectWarp_o`.
- `issueEntry_i` in 1: buffer `toSelectEntry_o`.
- `issueDstValid_i` in 1: destination valid bit of the selected packet.
- `issueDst_i` in `RW`: destination address of the selected packet.
- `wbValid_i` in 1: writeback strobe.
- `wbWarp_i` in `NUM_WARP_LOG`: writeback warp.
- `wbReg_i` in `RW`: writeback register.
- `hazardVector0_o` / `hazardVector1_o` out `NUM_WARP`: per-warp hazard for entry 0 / entry 1.
- `sbEmptyVector_o` out `NUM_WARP`: warp has no pending writes.
- `overflow_o` out 1: sticky; a reservation was attempted into a full warp.

## Operation
- State per warp:
  - Shadow entries s0 and s1, each holding a valid bit and four reg fields.
  - `SB_DEPTH` pending slots, each holding a valid bit and an address.
- Capture: when `decodedPacketNValid_i && !stall_i && !(flush_i && flushWarp_i==decodedWarp_i)`, write `decodedRegsN_i` into shadow N of `decodedWarp_i` and set its valid bit. This uses the same qualification as the buffer's RAM write enable.
- Issue is qualified as: `issueValid_i && !stall_i && !(flush_i && flushWarp_i==issueWarp_i)`. A qualified issue does two things:
  - Clears shadow `issueEntry_i` valid for `issueWarp_i`.
  - If `issueDstValid_i`, reserves the lowest free slot of `issueWarp_i` with `issueDst_i`. If no slot is free, the reservation is dropped and `overflow_o` is set.
- Capture beats issue-clear when both target the same warp and entry: shadow valid ends at 1 with the new fields.
- Flush: clears s0 and s1 valid of `flushWarp_i`. Pending slots are untouched, because in-flight writes still retire.
- Writeback: not gated by `stall_i`. Clears every valid slot of `wbWarp_i` whose address equals `wbReg_i`. A writeback with no matching slot is ignored.
- Writeback and reservation in the same cycle on the same warp both take effect. The writeback clear is evaluated on pre-cycle state.
- Hazard for entry N of warp w is 1 when shadow N is valid and either of these holds:
  - Any valid field k=0..3 has an address matching any valid pending slot of w (RAW and WAW).
  - Dest field valid and all `SB_DEPTH` slots of w are valid.
- When shadow N is invalid, the hazard is 0.
- `sbEmptyVector_o[w]` = no valid slot in w.

## Timing
- Hazard outputs are purely combinational from registered state. There is no input-to-output combinational path.
- Latency:
  - A reservation is visible in the hazard outputs the cycle after the selection cycle. This matches the buffer clearing its valid bit in the same cycle.
  - Writeback release is visible in the hazard outputs the cycle after `wbValid_i`. There is no bypass.
  - A capture is visible the cycle after the decode write.
- Reset values:
  - All shadow and slot valid bits: 0.
  - `hazardVector0_o` = `hazardVector1_o` = 0.
  - `sbEmptyVector_o` = all ones.
  - `overflow_o` = 0.
- Reset mid-operation discards all reservations; outstanding writebacks after reset are ignored.
- While `stall_i`=1, capture and issue are frozen; writebacks still release slots.

## Configuration
- `SB_INORDER_EN` defined:
  - `hazardVector1_o[w]` is additionally forced to 1 while s0 of w is valid, so entry 1 never issues ahead of entry 0.
  - `hazardVector0_o` is unaffected.
- `SB_INORDER_EN` undefined: entries are independent; only register hazards apply.

## Test plan
- Reset, then decode warp 2 entry 0 with src r3 and dest r7; select it; then decode warp 2 entry 1 with src r7.
  - Required: `hazardVector1_o[2]`=1 and `sbEmptyVector_o[2]`=0.
  - Then `wbValid_i` with warp 2, r7. Required: `hazardVector1_o[2]`=0 one cycle later and `sbEmptyVector_o[2]`=1.
- Issue four distinct dests r1–r4 on warp 0 (`SB_DEPTH`=4), then buffer an entry with dest r9.
  - Required: hazard=1.
  - Force a fifth reservation. Required: `overflow_o`=1 and it stays set until reset.
- Select warp 1 with dest r5 while `flush_i`=1 and `flushWarp_i`=1.
  - Required: no reservation, `sbEmptyVector_o[1]`=1, and shadow s0 of warp 1 cleared.
- Hold `stall_i`=1 with issue valid for 3 cycles, then release.
  - Required: exactly one reservation is made.
  - A writeback during the stall still clears its slot.
- Same-cycle decode write and selection on warp 3 entry 0.
  - Required: shadow valid remains 1 with the new sources.
  - The old dest is reserved.
- With `SB_INORDER_EN`, entry 0 of warp 0 valid and hazard-free, entry 1 hazard-free: `hazardVector1_o[0]`=1.
  - Without the macro: `hazardVector1_o[0]`=0.
